// File: rtl/gpu_cmd_pkg.sv
// Shared types and status-word layout for the GPU command sequencer.
package gpu_cmd_pkg;

  typedef enum logic [2:0] {
    CLEAR      = 3'd0,
    SET_START  = 3'd1,
    SET_END    = 3'd2,
    SET_COLOR  = 3'd3,
    MOVE_START = 3'd4,
    MOVE_END   = 3'd5,
    DRAW       = 3'd6,
    FLIP       = 3'd7
  } opcode_e;

  typedef enum logic {
    ENG_CLEAR = 1'b0,
    ENG_DRAW  = 1'b1
  } eng_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seq_state_e;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_BUSY      = 8;
  localparam int ST_FB_SEL    = 9;
  localparam int ST_OVERFLOW  = 10;
  localparam int ST_DROP_LSB  = 16;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// APB command front end: queues command words, updates geometry/colour and launches engine jobs.
// Build macro GPU_DROP_COUNT_EN adds a saturating dropped-push counter in status bits [23:16].
module gpu_cmd_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        psel,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        eng_start,
  output logic        eng_op,
  input  logic        eng_done,
  output logic [8:0]  start_x,
  output logic [7:0]  start_y,
  output logic [8:0]  end_x,
  output logic [7:0]  end_y,
  output logic [23:0] color,
  output logic        fb_sel
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

  seq_state_e  state_reg, state_next;
  eng_op_e     eng_op_reg;
  logic        wr_prev_reg, rd_prev_reg, overflow_reg, fb_sel_reg;
  logic [26:0] cmd_reg;
  logic [8:0]  start_x_reg, end_x_reg;
  logic [7:0]  start_y_reg, end_y_reg;
  logic [23:0] color_reg;

  logic        wr_req, rd_req, push, pop, rd_rise, drop, busy;
  logic        fifo_full, fifo_empty;
  logic [26:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic [7:0]  drop_cnt;
  logic [31:0] status;
  logic        unused_bits;

  assign wr_req      = psel & pwrite;
  assign rd_req      = psel & ~pwrite;
  assign push        = wr_req & ~wr_prev_reg;
  assign rd_rise     = rd_req & ~rd_prev_reg;
  assign drop        = push & fifo_full & ~pop;
  assign unused_bits = ^pwdata[31:27];

  gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(27)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (pwdata[26:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  opcode_e            cmd_op;
  logic [23:0]        payload;
  logic [8:0]         base_x, clamp_x;
  logic [7:0]         base_y, clamp_y;
  logic signed [10:0] sum_x, sum_y;

  assign cmd_op  = opcode_e'(cmd_reg[26:24]);
  assign payload = cmd_reg[23:0];
  assign base_x  = (cmd_op == MOVE_END) ? end_x_reg : start_x_reg;
  assign base_y  = (cmd_op == MOVE_END) ? end_y_reg : start_y_reg;
  // Offsets are sign-extended; 11 bits cover every base+offset without wrap.
  assign sum_x   = $signed({2'b00, base_x}) + $signed({{2{payload[16]}}, payload[16:8]});
  assign sum_y   = $signed({3'b000, base_y}) + $signed({{3{payload[7]}}, payload[7:0]});

  always_comb begin
    if (sum_x[10])          clamp_x = '0;
    else if (sum_x > X_MAX) clamp_x = X_MAX[8:0];
    else                    clamp_x = sum_x[8:0];
    if (sum_y[10])          clamp_y = '0;
    else if (sum_y > Y_MAX) clamp_y = Y_MAX[7:0];
    else                    clamp_y = sum_y[7:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    eng_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = (cmd_op == CLEAR || cmd_op == DRAW) ? ISSUE : IDLE;
      ISSUE: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (eng_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_reg     <= '0;
      start_x_reg <= '0;
      start_y_reg <= '0;
      end_x_reg   <= '0;
      end_y_reg   <= '0;
      color_reg   <= '0;
      fb_sel_reg  <= 1'b0;
      eng_op_reg  <= ENG_CLEAR;
    end else begin
      if (pop) cmd_reg <= fifo_head;
      if (state_reg == EXEC) begin
        case (cmd_op)
          CLEAR:      eng_op_reg <= ENG_CLEAR;
          DRAW:       eng_op_reg <= ENG_DRAW;
          SET_START:  begin start_x_reg <= payload[16:8]; start_y_reg <= payload[7:0]; end
          SET_END:    begin end_x_reg   <= payload[16:8]; end_y_reg   <= payload[7:0]; end
          SET_COLOR:  color_reg <= payload;
          MOVE_START: begin start_x_reg <= clamp_x; start_y_reg <= clamp_y; end
          MOVE_END:   begin end_x_reg   <= clamp_x; end_y_reg   <= clamp_y; end
          FLIP:       fb_sel_reg <= ~fb_sel_reg;
          default:    ;
        endcase
      end
    end
  end

  // Writes and reads are mutually exclusive, so set and clear never collide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_prev_reg  <= 1'b0;
      rd_prev_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_prev_reg <= wr_req;
      rd_prev_reg <= rd_req;
      if (drop)         overflow_reg <= 1'b1;
      else if (rd_rise) overflow_reg <= 1'b0;
    end
  end

`ifdef GPU_DROP_COUNT_EN
  logic [7:0] drop_cnt_reg;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_cnt_reg <= '0;
    end else if (drop) begin
      if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end else if (rd_rise) begin
      drop_cnt_reg <= '0;
    end
  end
  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 8'h00;
`endif

  assign busy = (state_reg != IDLE) | ~fifo_empty;

  always_comb begin
    status                      = '0;
    status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
    status[ST_BUSY]             = busy;
    status[ST_FB_SEL]           = fb_sel_reg;
    status[ST_OVERFLOW]         = overflow_reg;
    status[ST_DROP_LSB +: 8]    = drop_cnt;
    prdata                      = rd_req ? status : 32'h0;
  end

  assign eng_op  = eng_op_reg;
  assign start_x = start_x_reg;
  assign start_y = start_y_reg;
  assign end_x   = end_x_reg;
  assign end_y   = end_y_reg;
  assign color   = color_reg;
  assign fb_sel  = fb_sel_reg;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Directed bench for gpu_cmd_sequencer; drives and samples one ns after each falling clock edge.
module tb_gpu_cmd_sequencer;
  localparam logic [2:0] C_CLEAR = 3'd0, C_SSTART = 3'd1, C_SEND = 3'd2, C_SCOL = 3'd3;
  localparam logic [2:0] C_MSTART = 3'd4, C_MEND = 3'd5, C_DRAW = 3'd6, C_FLIP = 3'd7;

  logic        clk = 1'b0, n_rst = 1'b0, psel = 1'b0, pwrite = 1'b0, eng_done = 1'b0;
  logic [31:0] pwdata = '0, prdata;
  logic        eng_start, eng_op, fb_sel;
  logic [8:0]  start_x, end_x;
  logic [7:0]  start_y, end_y;
  logic [23:0] color;
  int          n_cmp = 0, n_bad = 0, start_cnt = 0;

  gpu_cmd_sequencer dut (
    .clk(clk), .n_rst(n_rst), .psel(psel), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .eng_start(eng_start), .eng_op(eng_op), .eng_done(eng_done),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .color(color), .fb_sel(fb_sel)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (eng_start) start_cnt++;

  function automatic logic [31:0] cmd(input logic [2:0] op, input logic [23:0] pl);
    return {5'b0, op, pl};
  endfunction

  function automatic logic [23:0] xy(input logic [8:0] x, input logic [7:0] y);
    return {7'b0, x, y};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apb_wr(input logic [31:0] w, input int hold);
    tick();
    psel = 1'b1; pwrite = 1'b1; pwdata = w;
    repeat (hold) tick();
    psel = 1'b0; pwrite = 1'b0;
    $display("write %08h held %0d", w, hold);
  endtask

  task automatic apb_rd(output logic [31:0] v);
    tick();
    psel = 1'b1; pwrite = 1'b0;
    #1 v = prdata;
    tick();
    psel = 1'b0;
    $display("read  %08h", v);
  endtask

  task automatic wait_start(output logic got, output logic op);
    got = 1'b0; op = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (eng_start) begin got = 1'b1; op = eng_op; end
    end
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_rst = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    n_cmp++;
    if ({eng_start, eng_op, start_x, start_y, end_x, end_y, color, fb_sel} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %0h want 0", {eng_start, eng_op, start_x, start_y, end_x, end_y, color, fb_sel});
    end
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status got %08h want 00000000", v); end
  endtask

  task automatic test_enqueue_hold();
    logic [31:0] v;
    apb_wr(cmd(C_SCOL, 24'hFF0000), 2);
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL single_enqueue_status got %08h want 00000000", v); end
    n_cmp++;
    if (color !== 24'hFF0000) begin n_bad++; $display("FAIL hold_color got %06h want ff0000", color); end
  endtask

  task automatic test_draw_stall();
    logic got, op;
    logic [31:0] v;
    int base, changes;
    apb_wr(cmd(C_SSTART, xy(9'd10, 8'd20)), 1);
    base = start_cnt;
    apb_wr(cmd(C_DRAW, 24'h0), 1);
    wait_start(got, op);
    n_cmp++;
    if (got !== 1'b1 || op !== 1'b1) begin n_bad++; $display("FAIL draw_start got start=%0b op=%0b want 1/1", got, op); end
    n_cmp++;
    if (start_x !== 9'd10 || start_y !== 8'd20) begin n_bad++; $display("FAIL draw_start_xy got %0d,%0d want 10,20", start_x, start_y); end
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (start_x !== 9'd10 || start_y !== 8'd20 || eng_start !== 1'b0) changes++;
    end
    n_cmp++;
    if (changes != 0) begin n_bad++; $display("FAIL stall_stable got %0d changes want 0", changes); end
    n_cmp++;
    if (start_cnt != base + 1) begin n_bad++; $display("FAIL draw_pulse_count got %0d want %0d", start_cnt - base, 1); end
    pulse_done();
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL draw_idle_status got %08h want 00000000", v); end
  endtask

  task automatic test_clamp();
    apb_wr(cmd(C_SSTART, xy(9'd315, 8'd5)), 1);
    apb_wr(cmd(C_MSTART, xy(9'd10, 8'hF8)), 1);
    repeat (4) tick();
    n_cmp++;
    if (start_x !== 9'd319 || start_y !== 8'd0) begin n_bad++; $display("FAIL clamp_hi_lo got %0d,%0d want 319,0", start_x, start_y); end
    apb_wr(cmd(C_MSTART, xy(9'h100, 8'd0)), 1);
    repeat (4) tick();
    n_cmp++;
    if (start_x !== 9'd63) begin n_bad++; $display("FAIL move_neg got %0d want 63", start_x); end
    apb_wr(cmd(C_MSTART, xy(9'h100, 8'd0)), 1);
    repeat (4) tick();
    n_cmp++;
    if (start_x !== 9'd0) begin n_bad++; $display("FAIL clamp_x_zero got %0d want 0", start_x); end
    apb_wr(cmd(C_SEND, xy(9'd0, 8'd239)), 1);
    apb_wr(cmd(C_MEND, xy(9'd5, 8'd3)), 1);
    repeat (4) tick();
    n_cmp++;
    if (end_x !== 9'd5 || end_y !== 8'd239 || start_x !== 9'd0 || start_y !== 8'd0) begin
      n_bad++; $display("FAIL move_end got end %0d,%0d start %0d,%0d want 5,239 0,0", end_x, end_y, start_x, start_y);
    end
  endtask

  task automatic test_ordering();
    logic got, op;
    int fb_at, col_at;
    apb_wr(cmd(C_DRAW, 24'h0), 1);
    wait_start(got, op);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL order_start got %0b want 1", got); end
    apb_wr(cmd(C_FLIP, 24'h0), 1);
    apb_wr(cmd(C_SCOL, 24'h00FF00), 1);
    repeat (10) tick();
    n_cmp++;
    if (fb_sel !== 1'b0 || color !== 24'hFF0000) begin n_bad++; $display("FAIL order_held got fb=%0b col=%06h want 0/ff0000", fb_sel, color); end
    pulse_done();
    fb_at = -1; col_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fb_at < 0 && fb_sel === 1'b1) fb_at = i;
      if (col_at < 0 && color === 24'h00FF00) col_at = i;
    end
    n_cmp++;
    if (fb_at < 0 || col_at < 0 || fb_at >= col_at) begin n_bad++; $display("FAIL order_seq got fb_at=%0d col_at=%0d want 0<=fb_at<col_at", fb_at, col_at); end
  endtask

  task automatic test_overflow();
    logic got, op;
    logic [31:0] v, exp1;
    apb_wr(cmd(C_DRAW, 24'h0), 1);
    wait_start(got, op);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL ovf_start got %0b want 1", got); end
    for (int i = 0; i < 6; i++) apb_wr(cmd(C_SCOL, 24'h0A0000 + 24'(i)), 1);
`ifdef GPU_DROP_COUNT_EN
    exp1 = 32'h0002_0704;
`else
    exp1 = 32'h0000_0704;
`endif
    apb_rd(v);
    n_cmp++;
    if (v !== exp1) begin n_bad++; $display("FAIL ovf_status got %08h want %08h", v, exp1); end
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0000_0304) begin n_bad++; $display("FAIL ovf_cleared got %08h want 00000304", v); end
    pulse_done();
    repeat (12) tick();
    n_cmp++;
    if (color !== 24'h0A0003) begin n_bad++; $display("FAIL ovf_drain_color got %06h want 0a0003", color); end
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0000_0200) begin n_bad++; $display("FAIL ovf_drain_status got %08h want 00000200", v); end
  endtask

  task automatic test_reset_mid_job();
    logic got, op;
    logic [31:0] v;
    int base;
    apb_wr(cmd(C_SSTART, xy(9'd100, 8'd50)), 1);
    apb_wr(cmd(C_CLEAR, 24'h0), 1);
    wait_start(got, op);
    n_cmp++;
    if (got !== 1'b1 || op !== 1'b0) begin n_bad++; $display("FAIL clear_start got start=%0b op=%0b want 1/0", got, op); end
    apb_wr(cmd(C_SCOL, 24'h123456), 1);
    tick();
    n_rst = 1'b0;
    psel = 1'b1; pwrite = 1'b0;
    #1;
    n_cmp++;
    if ({eng_start, eng_op, start_x, start_y, end_x, end_y, color, fb_sel} !== '0 || prdata !== 32'h0) begin
      n_bad++; $display("FAIL midjob_reset got outs=%0h status=%08h want 0/0", {eng_start, eng_op, start_x, start_y, end_x, end_y, color, fb_sel}, prdata);
    end
    psel = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    base = start_cnt;
    pulse_done();
    repeat (5) tick();
    n_cmp++;
    if (start_cnt != base || color !== 24'h0) begin n_bad++; $display("FAIL late_done got pulses=%0d col=%06h want 0/000000", start_cnt - base, color); end
    apb_rd(v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL post_reset_status got %08h want 00000000", v); end
  endtask

  initial begin
    test_reset();
    test_enqueue_hold();
    test_draw_stall();
    test_clamp();
    test_ordering();
    test_overflow();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
